// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : inst_encoder
//  Purpose  : Packs RV32I instruction fields into a 32-bit word behind a
//             valid/ready handshake with a 2-entry output FIFO.
//  Option   : INST_ENC_RANGE_CHECK_EN builds per-entry immediate/format checks.
//  Revision : 1.0  initial release
// ============================================================================
module inst_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [15:0] enc_count
);

  localparam logic [2:0]  FMT_R = 3'd0;
  localparam logic [2:0]  FMT_I = 3'd1;
  localparam logic [2:0]  FMT_S = 3'd2;
  localparam logic [2:0]  FMT_B = 3'd3;
  localparam logic [2:0]  FMT_U = 3'd4;
  localparam logic [2:0]  FMT_J = 3'd5;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam logic [1:0]  FIFO_DEPTH = 2'd2;

  // --------------------------------------------------------------------------
  // Field packing
  // --------------------------------------------------------------------------
  logic [31:0] enc_word;

  always_comb begin
    enc_word = NOP_WORD;
    case (in_fmt)
      FMT_R: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      FMT_S: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:0], in_opcode};
      FMT_B: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], in_opcode};
      FMT_U: enc_word = {in_imm[31:12], in_rd, in_opcode};
      FMT_J: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                         in_rd, in_opcode};
      default: enc_word = NOP_WORD;
    endcase
  end

  // --------------------------------------------------------------------------
  // Handshake and FIFO bookkeeping
  // --------------------------------------------------------------------------
  logic        in_ready_q;
  logic        out_valid_q;
  logic [1:0]  count_q;
  logic [1:0]  count_d;
  logic        head_q;
  logic        tail_q;
  logic [15:0] enc_count_q;
  logic [31:0] mem_q [2];
  logic        push;
  logic        pop;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Flags are registered from count_d so neither handshake side sees a
  // combinational path from the other.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= 2'd0;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      enc_count_q <= 16'd0;
      mem_q[0]    <= 32'd0;
      mem_q[1]    <= 32'd0;
    end else begin
      if (push) begin
        mem_q[tail_q] <= enc_word;
        tail_q        <= ~tail_q;
        enc_count_q   <= enc_count_q + 16'd1;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
      count_q     <= count_d;
      in_ready_q  <= (count_d < FIFO_DEPTH);
      out_valid_q <= (count_d != 2'd0);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_inst  = mem_q[head_q];
  assign enc_count = enc_count_q;

  // --------------------------------------------------------------------------
  // Optional range / format checking
  // --------------------------------------------------------------------------
`ifdef INST_ENC_RANGE_CHECK_EN
  logic        chk_err;
  logic [1:0]  err_q;
  logic signed [31:0] imm_s;

  assign imm_s = $signed(in_imm);

  always_comb begin
    chk_err = 1'b0;
    case (in_fmt)
      FMT_R: chk_err = 1'b0;
      FMT_I, FMT_S:
        chk_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      FMT_B:
        chk_err = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || in_imm[0];
      FMT_U: chk_err = (in_imm[11:0] != 12'd0);
      FMT_J:
        chk_err = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || in_imm[0];
      default: chk_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 2'b00;
    end else if (push) begin
      err_q[tail_q] <= chk_err;
    end
  end

  assign out_err = err_q[head_q];
`else
  assign out_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// Scoreboard bench for inst_encoder: directed vectors plus randomized traffic
// checked against an arithmetic reference model.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] enc_count;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];
  int unsigned acc_count = 0;

`ifdef INST_ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  inst_encoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err), .enc_count(enc_count)
  );

  always #5 clk = ~clk;

  // Bit-range extraction by shift-and-mask arithmetic.
  function automatic longint fld(input logic [31:0] v, input int hi, input int lo);
    longint u;
    u = longint'({32'd0, v});
    return (u >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
  endfunction

  function automatic logic [32:0] model(input logic [2:0] fmt, input logic [6:0] op,
      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    longint w;
    int     s;
    bit     e;
    s = int'(imm);
    w = 0;
    e = 1'b0;
    case (fmt)
      3'd0: w = f7 * 2**25 + rs2 * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + op;
      3'd1: begin
        w = fld(imm, 11, 0) * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + op;
        e = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        w = fld(imm, 11, 5) * 2**25 + rs2 * 2**20 + rs1 * 2**15 + f3 * 2**12
          + fld(imm, 4, 0) * 2**7 + op;
        e = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        w = fld(imm, 12, 12) * 2**31 + fld(imm, 10, 5) * 2**25 + rs2 * 2**20
          + rs1 * 2**15 + f3 * 2**12 + fld(imm, 4, 1) * 2**8
          + fld(imm, 11, 11) * 2**7 + op;
        e = (s < -4096) || (s > 4094) || (s % 2 != 0);
      end
      3'd4: begin
        w = (fld(imm, 31, 0) / 4096) * 4096 + rd * 2**7 + op;
        e = (fld(imm, 31, 0) % 4096) != 0;
      end
      3'd5: begin
        w = fld(imm, 20, 20) * 2**31 + fld(imm, 10, 1) * 2**21
          + fld(imm, 11, 11) * 2**20 + fld(imm, 19, 12) * 2**12 + rd * 2**7 + op;
        e = (s < -1048576) || (s > 1048574) || (s % 2 != 0);
      end
      default: begin
        w = 19;
        e = 1'b1;
      end
    endcase
    return {e & RC, w[31:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  // Monitor: pop expected entry on every output transfer.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [32:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %h/%0b required nothing", out_inst, out_err);
      end else begin
        e = exp_q.pop_front();
        if (out_inst !== e[31:0] || out_err !== e[32]) begin
          errors++;
          $display("FAIL output_word: got %h err %0b required %h err %0b",
                   out_inst, out_err, e[31:0], e[32]);
        end
      end
    end
  end

  task automatic set_fields(input logic [2:0] fmt, input logic [6:0] op,
      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    in_fmt = fmt; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  // Present one word, wait (bounded) for acceptance, push its expectation.
  task automatic send(input logic [32:0] expv);
    bit done = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(expv);
        acc_count++;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 required 1 within 50 cycles");
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] rand_imm();
    int k;
    k = int'($urandom_range(0, 5));
    case (k)
      0: return $urandom;
      1: return 32'($signed($urandom_range(0, 8191)) - 4096);
      2: return 32'($signed($urandom_range(0, 4095)) - 2048);
      3: return $urandom & 32'hFFFF_F000;
      4: return 32'($signed($urandom_range(0, 2097151)) - 1048576) & 32'hFFFF_FFFE;
      default: begin
        int b[8] = '{2047, -2048, 2048, 4094, -4096, 4096, 1048574, -1048576};
        return 32'(b[$urandom_range(0, 7)]);
      end
    endcase
  endfunction

  initial begin
    logic [31:0] ri;
    logic [2:0]  rf;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_fields(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_inst", out_inst, 32'd0);
    check("reset_out_err", 32'(out_err), 32'd0);
    check("reset_enc_count", 32'(enc_count), 32'd0);
    @(posedge clk); #1;

    // Directed vectors with known encodings.
    out_ready = 1'b1;
    set_fields(3'd1, 7'h13, 3'd0, 7'd0, 5'd8, 5'd9, 5'd0, 32'hFFFF_FFFF);
    send({1'b0, 32'hfff48413});
    set_fields(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd9, 5'd8, 32'd1234);
    send({1'b0, 32'h4c84a923});
    set_fields(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd8, 5'd9, 32'd122);
    send({1'b0, 32'h06940d63});
    set_fields(3'd4, 7'h37, 3'd0, 7'd0, 5'd8, 5'd0, 5'd0, 32'h1000_0000);
    send({1'b0, 32'h10000437});
    set_fields(3'd5, 7'h6f, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd65536);
    send({1'b0, 32'h000100ef});
    set_fields(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd8, 5'd9, 32'd123);
    send({RC, 32'h06940d63});
    set_fields(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd2048);
    send({RC, 32'h80000013});
    set_fields(3'd7, 7'h33, 3'd5, 7'h20, 5'd3, 5'd4, 5'd5, 32'd99);
    send({RC, 32'h00000013});
    drain();

    // Backpressure: third word must stall until the consumer drains one.
    out_ready = 1'b0;
    set_fields(3'd0, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'd0);
    send({1'b0, 32'h403100b3});
    set_fields(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'd5);
    send({1'b0, 32'h00508093});
    set_fields(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd2, 5'd0, 32'd7);
    in_valid = 1'b1;
    @(negedge clk);
    check("bp_in_ready_full", 32'(in_ready), 32'd0);
    check("bp_count_before", 32'(enc_count), 32'(acc_count[15:0]));
    @(posedge clk); #1;
    out_ready = 1'b1;
    send({1'b0, 32'h00710113});
    @(negedge clk);
    check("bp_count_after", 32'(enc_count), 32'(acc_count[15:0]));
    drain();

    // Randomized traffic with random consumer backpressure.
    for (int n = 0; n < 600; n++) begin
      ri = rand_imm();
      rf = 3'($urandom_range(0, 7));
      set_fields(rf, 7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom),
                 5'($urandom), 5'($urandom), ri);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_fmt, in_opcode, in_funct3, in_funct7,
                              in_rd, in_rs1, in_rs2, in_imm));
        acc_count++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    check("rand_enc_count", 32'(enc_count), 32'(acc_count[15:0]));

    // Reset with two entries queued discards them.
    out_ready = 1'b0;
    set_fields(3'd4, 7'h17, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h0000_3000);
    send({1'b0, 32'h00003297});
    send({1'b0, 32'h00003297});
    @(negedge clk);
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    acc_count = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_enc_count", 32'(enc_count), 32'd0);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
